id_issue_ctrl: RTL
==================

// Module: id_issue_ctrl
// PURPOSE
//  Issue controller between decode and execute of the RV32I pipeline. Takes decoded fields
//  (opcode/rd/rs1/rs2) of the instruction held in ID. Tracks in-flight destination registers
//  in a scoreboard. Stalls on RAW hazards or when the in-flight limit is reached. Drops the
//  held instruction on flush. Counts stall cycles for performance monitoring.
// PARAMETERS
//  MAX_INFLIGHT   4   max issued-but-not-retired instructions (1..15)
//  RETIRE_BYPASS  1   1: a register retiring this cycle does not cause a hazard
//  CNT_W          32  width of stall_cycles counter
// PORTS
//  clk            in   1      clock, rising edge
//  arst_n         in   1      async reset, active low
//  in_valid       in   1      ID holds a valid decoded instruction
//  in_ready       out  1      ID instruction consumed (issued or dropped) this cycle
//  opcode         in   7      decoded opcode
//  rd             in   5      decoded destination
//  rs1            in   5      decoded source 1
//  rs2            in   5      decoded source 2
//  out_valid      out  1      instruction offered to EX
//  out_ready      in   1      EX accepts
//  flush          in   1      kill instruction held in ID (branch/jump redirect)
//  retire_valid   in   1      one issued instruction retires
//  retire_we      in   1      retiring instruction writes retire_rd
//  retire_rd      in   5      retiring destination
//  busy_regs      out  32     scoreboard, bit i = write to x(i) pending; bit 0 always 0
//  inflight       out  4      issued-not-retired count
//  stall          out  1      in_valid & ~flush & ~issue_ok
//  stall_cycles   out  CNT_W  saturating count of cycles with stall=1
// BEHAVIOUR
//  Reset: busy_regs=0, inflight=0, stall_cycles=0, state=RUN. out_valid=0 and in_ready=0 while
//   in_valid=0 and during reset.
//  Decode classes (pkg): writes_rd = LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, and only when rd!=0.
//   uses_rs1 = all except LUI, AUIPC, JAL. uses_rs2 = BRANCH, STORE, OP. Unknown opcode: no
//   reads or writes, issued as-is.
//  busy_eff = busy_regs & ~(RETIRE_BYPASS & retire_valid & retire_we ? onehot(retire_rd) : 0).
//  raw = (uses_rs1 & busy_eff[rs1]) | (uses_rs2 & busy_eff[rs2]). x0 is never busy.
//  full = (inflight == MAX_INFLIGHT) & ~retire_valid. A same-cycle retire frees the slot.
//  issue_ok = ~raw & ~full.
//  out_valid = in_valid & ~flush & issue_ok (combinational).
//  in_ready = flush | (out_valid & out_ready).
//  fire = out_valid & out_ready.
//  Handshake: out_valid may fall without fire only on flush or a new hazard. Fields are stable
//   while in_valid & ~in_ready.
//  Scoreboard next state: clear bit retire_rd if retire_valid&retire_we. Set bit rd if
//   fire&writes_rd. If the same register is cleared and set in one cycle, the set wins.
//  Inflight next state: +fire -retire_valid. Simultaneous fire and retire leaves it unchanged.
//   A retire at inflight=0 is a protocol error: SVA assertion, and the counter holds at 0.
//  Latency: issue decision is zero-cycle. busy_regs/inflight reflect a fire on the next cycle.
//  FSM (observable via stall and stall_cycles), evaluated each cycle:
//   RUN       -> STALL_RAW  if in_valid&~flush&raw
//   RUN       -> STALL_FULL if in_valid&~flush&~raw&full
//   STALL_*   -> RUN        on fire, flush, or in_valid=0
//   STALL_RAW <-> STALL_FULL as the raw/full cause changes. raw has priority.
//   out_ready=0 with issue_ok=1 is backpressure, not a stall: stays in RUN.
//  stall_cycles increments when stall=1 and saturates at all-ones.
//  Flush with in_valid=0: no effect. Flush never touches busy_regs/inflight, since issued
//   instructions always retire.
//  Async reset mid-operation: all state cleared immediately, counter included.
// STRUCTURE
//  pkg rv_pkg: opcode localparams (OP_LUI..OP_OP) and typedef enum {RUN,STALL_RAW,STALL_FULL}
//   issue_state_e.
//  Sub-module rv_scoreboard: busy_regs + inflight, set/clear/bypass logic.
//  Top holds class decode, handshake, FSM and stall counter.
// TESTING
//  ADDI x5 issued, then ADD x6,x5,x1 next cycle, no retire -> stall=1, out_valid=0,
//   STALL_RAW until retire(x5). Same cycle issue with RETIRE_BYPASS=1; next cycle with 0.
//  4 independent ops issue, no retire (MAX=4) -> inflight=4, 5th gives STALL_FULL.
//   retire_valid that cycle -> 5th fires, inflight stays 4.
//  Same cycle: retire x7 and fire ADDI x7 -> busy_regs[7]=1 next cycle.
//  LUI x0 / STORE with busy rs2 -> x0 not marked busy; STORE stalls on rs2, LUI never stalls.
//  flush during STALL_RAW -> in_ready=1, out_valid=0, state RUN, busy_regs unchanged.
//  stall_cycles with CNT_W=4 forced over 20 stall cycles -> saturates at 15. arst_n pulse
//   mid-run -> all outputs 0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I issue-stage definitions: opcode constants, issue FSM states
// and the per-opcode register usage classes.
package rv_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    STALL_RAW  = 2'd1,
    STALL_FULL = 2'd2
  } issue_state_e;

  // x0 writes are architecturally discarded, so they never occupy the scoreboard.
  function automatic logic writes_rd(input logic [6:0] opcode, input logic [4:0] rd);
    logic w;
    unique case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_OP_IMM, OP_OP: w = 1'b1;
      default:                                                     w = 1'b0;
    endcase
    return w & (rd != 5'd0);
  endfunction

  function automatic logic uses_rs1(input logic [6:0] opcode);
    logic u;
    unique case (opcode)
      OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_OP_IMM, OP_OP: u = 1'b1;
      default:                                                u = 1'b0;
    endcase
    return u;
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    logic u;
    unique case (opcode)
      OP_BRANCH, OP_STORE, OP_OP: u = 1'b1;
      default:                    u = 1'b0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/id_issue_ctrl_if.sv
// Decode-to-execute issue bus: ID instruction handshake, EX acceptance,
// flush redirect and retire notification.
interface id_issue_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] opcode;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       out_valid;
  logic       out_ready;
  logic       flush;
  logic       retire_valid;
  logic       retire_we;
  logic [4:0] retire_rd;

  modport master (
    output in_valid, opcode, rd, rs1, rs2, out_ready, flush,
           retire_valid, retire_we, retire_rd,
    input  in_ready, out_valid
  );

  modport slave (
    input  in_valid, opcode, rd, rs1, rs2, out_ready, flush,
           retire_valid, retire_we, retire_rd,
    output in_ready, out_valid
  );
endinterface

// File: rtl/rv_scoreboard.sv
// Pending-write scoreboard and in-flight counter for the issue stage,
// including the same-cycle retire bypass view used for hazard checks.
module rv_scoreboard #(
  parameter int unsigned MaxInflight  = 4,
  parameter bit          RetireBypass = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fire_i,
  input  logic        set_i,
  input  logic [4:0]  set_rd_i,
  input  logic        retire_valid_i,
  input  logic        retire_we_i,
  input  logic [4:0]  retire_rd_i,
  output logic [31:0] busy_eff_o,
  output logic [31:0] busy_regs_o,
  output logic [3:0]  inflight_o,
  output logic        full_o
);

  logic [31:0] busy_q, busy_d, clr_mask, set_mask;
  logic [3:0]  inflight_q, inflight_d;

  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (retire_valid_i && retire_we_i) clr_mask[retire_rd_i] = 1'b1;
    if (set_i)                         set_mask[set_rd_i]    = 1'b1;
    // Set applied after clear so a same-cycle reissue of the register keeps it busy.
    busy_d     = ((busy_q & ~clr_mask) | set_mask) & ~32'd1;
    busy_eff_o = RetireBypass ? (busy_q & ~clr_mask) : busy_q;

    inflight_d = inflight_q;
    if (fire_i && !retire_valid_i) begin
      inflight_d = inflight_q + 4'd1;
    end else if (!fire_i && retire_valid_i && (inflight_q != 4'd0)) begin
      inflight_d = inflight_q - 4'd1;
    end
    full_o = (inflight_q == 4'(MaxInflight)) && !retire_valid_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q     <= '0;
      inflight_q <= '0;
    end else begin
      busy_q     <= busy_d;
      inflight_q <= inflight_d;
    end
  end

  assign busy_regs_o = busy_q;
  assign inflight_o  = inflight_q;

  a_retire_underflow: assert property (
    @(posedge clk_i) disable iff (!rst_ni) !(retire_valid_i && (inflight_q == 4'd0))
  );

endmodule

// File: rtl/id_issue_ctrl.sv
// ID-to-EX issue controller: RAW / in-flight-limit stalls, flush drop,
// stall-state tracking and a saturating stall-cycle counter.
module id_issue_ctrl
  import rv_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT  = 4,
  parameter bit          RETIRE_BYPASS = 1'b1,
  parameter int unsigned CNT_W         = 32
) (
  input  logic              clk,
  input  logic              arst_n,
  id_issue_ctrl_if.slave    bus,
  output logic [31:0]       busy_regs,
  output logic [3:0]        inflight,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cycles
);

  logic [31:0]      busy_eff;
  logic             full, raw, issue_ok, live, out_valid_w, fire, set_busy;
  issue_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    raw = (uses_rs1(bus.opcode) & busy_eff[bus.rs1]) |
          (uses_rs2(bus.opcode) & busy_eff[bus.rs2]);
    issue_ok    = ~raw & ~full;
    // Gating with arst_n keeps the handshake quiet while reset is asserted.
    live        = arst_n & bus.in_valid & ~bus.flush;
    out_valid_w = live & issue_ok;
    fire        = out_valid_w & bus.out_ready;
    set_busy    = fire & writes_rd(bus.opcode, bus.rd);
    stall       = live & ~issue_ok;
  end

  assign bus.out_valid = out_valid_w;
  assign bus.in_ready  = arst_n & bus.in_valid & (bus.flush | fire);

  rv_scoreboard #(
    .MaxInflight  (MAX_INFLIGHT),
    .RetireBypass (RETIRE_BYPASS)
  ) u_scoreboard (
    .clk_i          (clk),
    .rst_ni         (arst_n),
    .fire_i         (fire),
    .set_i          (set_busy),
    .set_rd_i       (bus.rd),
    .retire_valid_i (bus.retire_valid),
    .retire_we_i    (bus.retire_we),
    .retire_rd_i    (bus.retire_rd),
    .busy_eff_o     (busy_eff),
    .busy_regs_o    (busy_regs),
    .inflight_o     (inflight),
    .full_o         (full)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (live && raw)       state_d = STALL_RAW;
        else if (live && full) state_d = STALL_FULL;
      end
      STALL_RAW, STALL_FULL: begin
        if (fire || bus.flush || !bus.in_valid) state_d = RUN;
        else if (raw)                           state_d = STALL_RAW;
        else if (full)                          state_d = STALL_FULL;
        else                                    state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_cycles = cnt_q;

endmodule
